sram_controller: RTL

//  Responder end of the MEM-stage data-memory interface. Accepts the pipeline's 32-bit rd/wr requests.

---
 rtl/sram_controller_pkg.sv | 21 ++
 rtl/sram_controller_if.sv | 22 ++
 rtl/sram_controller_wait_counter.sv | 28 ++
 rtl/sram_controller.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared widths, FSM encoding and request record for the SRAM controller
package arm_mem_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LO   = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef struct packed {
        logic              write;
        logic              oor;
        logic [WORD_W-1:0] data;
    } req_t;

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - pipeline-side data-memory request/response bundle
interface sram_controller_if;
    import arm_mem_pkg::*;

    logic              rd_en;
    logic              wr_en;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// rtl/sram_controller_wait_counter.sv - loadable down-counter timing the post-access settle window
module sram_wait_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on entry to the settle window, then count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - serves 32-bit MEM-stage accesses as two 16-bit async SRAM cycles; optional SRAM_CTRL_BOUNDS_CHECK_EN adds addr_err
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    inout  wire  [HALF_W-1:0] sram_dq,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    ,
    output logic              addr_err
`endif
);

    localparam int               CNT_W     = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [2:0]        state;
    req_t              req_q;
    logic [ADDR_W-2:0] word_q;
    logic [ADDR_W-2:0] word_in;
    logic [WORD_W-1:0] read_q;
    logic              req;
    logic              oor_in;
    logic              active;
    logic              wait_done;

    assign req     = bus.rd_en | bus.wr_en;
    assign word_in = (ADDR_W-1)'((bus.address - BASE_ADDR) >> 2);

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 1));

    assign oor_in = (bus.address < BASE_ADDR) || ({1'b0, bus.address} >= LIMIT);

    // Sticky flag: any out-of-range request accepted since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (state == ST_IDLE && req && oor_in) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign oor_in = 1'b0;
`endif

    sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .en         (state == ST_WAIT),
        .load       (state == ST_HI),
        .load_value (WAIT_LOAD),
        .done       (wait_done)
    );

    // Access sequencer; the request is latched in IDLE so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            req_q  <= '0;
            word_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state       <= ST_LO;
                        req_q.write <= bus.wr_en;
                        req_q.oor   <= oor_in;
                        req_q.data  <= bus.write_data;
                        word_q      <= word_in;
                    end
                end
                ST_LO:   state <= ST_HI;
                ST_HI:   state <= ST_WAIT;
                ST_WAIT: if (wait_done) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture each read halfword at the end of its SRAM cycle; writes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_q <= '0;
        end else if (!req_q.write) begin
            if (state == ST_LO) begin
                read_q[15:0] <= req_q.oor ? 16'h0000 : sram_dq;
            end else if (state == ST_HI) begin
                read_q[31:16] <= req_q.oor ? 16'h0000 : sram_dq;
            end
        end
    end

    assign bus.read_data = read_q;
    assign bus.ready     = (state == ST_IDLE && !req) || (state == ST_DONE);

    assign active = (state == ST_LO || state == ST_HI) && !req_q.oor;

    // SRAM strobes and halfword address derived from the current access phase.
    always_comb begin
        sram_addr = '0;
        sram_ce_n = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        if (state == ST_LO || state == ST_HI) begin
            sram_addr = {word_q, state == ST_HI};
        end
        if (active) begin
            sram_ce_n = 1'b0;
            sram_we_n = !req_q.write;
            sram_oe_n = req_q.write;
        end
    end

    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign sram_dq = (active && req_q.write)
                   ? ((state == ST_HI) ? req_q.data[31:16] : req_q.data[15:0])
                   : 16'hzzzz;

endmodule
